// File: rtl/ps2_key_ctrl_if.sv
// Handshake bundle between the PS/2 byte FIFO, the scan-to-ASCII lookup,
// the key controller and the key-event consumer.
interface ps2_key_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             code_valid;
    logic [7:0]       code;
    logic             code_ready;
    logic [7:0]       scan_out;
    logic [7:0]       ascii_in;
    logic             key_valid;
    logic             key_ready;
    logic [7:0]       key_ascii;
    logic [7:0]       key_scan;
    logic             key_down;
    logic [CNT_W-1:0] key_count;

    // The controller is the slave; the side supplying bytes, lookup data
    // and event acceptance is the master.
    modport slave (
        input  code_valid, code, ascii_in, key_ready,
        output code_ready, scan_out, key_valid, key_ascii, key_scan,
               key_down, key_count
    );

    modport master (
        output code_valid, code, ascii_in, key_ready,
        input  code_ready, scan_out, key_valid, key_ascii, key_scan,
               key_down, key_count
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Turns raw PS/2 scan bytes (make, E0, F0 prefixes) into ASCII key events,
// suppressing typematic repeats and tracking whether a key is held.
module ps2_key_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    ps2_key_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXT, BREAK, LOOK, OUT} state_t;

    state_t           r_state;
    logic [7:0]       r_heldScan;
    logic [7:0]       r_keyAscii;
    logic [7:0]       r_keyScan;
    logic             r_keyDown;
    logic             r_keyValid;
    logic             r_ext;
    logic [CNT_W-1:0] r_keyCount;

    logic             w_codeReady;
    logic             w_accept;

    assign w_codeReady = (r_state == IDLE) || (r_state == EXT) || (r_state == BREAK);
    assign w_accept    = bus.code_valid & w_codeReady;

    assign bus.code_ready = w_codeReady;
    assign bus.scan_out   = r_heldScan;
    assign bus.key_valid  = r_keyValid;
    assign bus.key_ascii  = r_keyAscii;
    assign bus.key_scan   = r_keyScan;
    assign bus.key_down   = r_keyDown;
    assign bus.key_count  = r_keyCount;

    // A repeat of the held key while it is still down is the keyboard's
    // typematic stream and must not generate a second event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_heldScan <= 8'h00;
            r_keyAscii <= 8'h00;
            r_keyScan  <= 8'h00;
            r_keyDown  <= 1'b0;
            r_keyValid <= 1'b0;
            r_ext      <= 1'b0;
            r_keyCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (bus.code == 8'hE0) begin
                            r_state <= EXT;
                        end else if (bus.code == 8'hF0) begin
                            r_state <= BREAK;
                        end else if (!(r_keyDown && (bus.code == r_heldScan))) begin
                            r_heldScan <= bus.code;
                            r_keyDown  <= 1'b1;
                            r_state    <= LOOK;
                        end
                    end
                end
                EXT: begin
                    if (w_accept) begin
                        if (bus.code == 8'hF0) begin
                            r_ext   <= 1'b1;
                            r_state <= BREAK;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                // Extended releases are swallowed so they never clear key_down.
                BREAK: begin
                    if (w_accept) begin
                        if (!r_ext && (bus.code == r_heldScan)) begin
                            r_keyDown <= 1'b0;
                        end
                        r_ext   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                LOOK: begin
                    if (bus.ascii_in != 8'h00) begin
                        r_keyAscii <= bus.ascii_in;
                        r_keyScan  <= r_heldScan;
                        r_keyValid <= 1'b1;
                        r_state    <= OUT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OUT: begin
                    if (bus.key_ready) begin
                        r_keyValid <= 1'b0;
                        r_keyCount <= r_keyCount + 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a small scan-to-ASCII table standing
// in for the lookup ROM.
module tb_ps2_key_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ps2_key_ctrl_if #(.CNT_W(8)) bus();

    ps2_key_ctrl #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lookup ROM model: 0x0E is deliberately unmapped.
    always_comb begin
        case (bus.scan_out)
            8'h1C:   bus.ascii_in = 8'h41;
            8'h32:   bus.ascii_in = 8'h42;
            8'h21:   bus.ascii_in = 8'h43;
            default: bus.ascii_in = 8'h00;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Presents one byte and returns 1ns after the edge that consumed it.
    task automatic applyStimulus(input logic [7:0] b);
        int waitCycles;
        @(negedge clk);
        bus.code_valid = 1'b1;
        bus.code       = b;
        waitCycles     = 0;
        while (!bus.code_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 50) checkOutput("pushTimeout", 32'(waitCycles), 32'd0);
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
    endtask

    task automatic deliverKey(input logic [7:0] b);
        applyStimulus(b);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
        bus.key_ready  = 1'b0;

        idleCycles(2);
        checkOutput("rstKeyValid", 32'(bus.key_valid), 32'd0);
        checkOutput("rstKeyDown",  32'(bus.key_down),  32'd0);
        checkOutput("rstScanOut",  32'(bus.scan_out),  32'h00);
        checkOutput("rstCount",    32'(bus.key_count), 32'd0);
        checkOutput("rstAscii",    32'(bus.key_ascii), 32'h00);
        checkOutput("rstScan",     32'(bus.key_scan),  32'h00);
        rst = 1'b0;
        idleCycles(1);
        checkOutput("postRstReady", 32'(bus.code_ready), 32'd1);

        // Single make byte with a consumer that is always ready.
        bus.key_ready = 1'b1;
        applyStimulus(8'h1C);
        checkOutput("lookNoValid", 32'(bus.key_valid),  32'd0);
        checkOutput("lookNoReady", 32'(bus.code_ready), 32'd0);
        idleCycles(1);
        checkOutput("evtValid",   32'(bus.key_valid), 32'd1);
        checkOutput("evtAscii",   32'(bus.key_ascii), 32'h41);
        checkOutput("evtScan",    32'(bus.key_scan),  32'h1C);
        checkOutput("evtDown",    32'(bus.key_down),  32'd1);
        checkOutput("evtCount0",  32'(bus.key_count), 32'd0);
        idleCycles(1);
        checkOutput("evtDone",    32'(bus.key_valid), 32'd0);
        checkOutput("evtCount1",  32'(bus.key_count), 32'd1);

        // Typematic repeats are dropped; a matching break releases the key.
        deliverKey(8'h1C);
        deliverKey(8'h1C);
        checkOutput("repeatCount", 32'(bus.key_count), 32'd1);
        checkOutput("repeatValid", 32'(bus.key_valid), 32'd0);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        idleCycles(2);
        checkOutput("breakDown",  32'(bus.key_down),  32'd0);
        checkOutput("breakCount", 32'(bus.key_count), 32'd1);

        // Re-press, then extended make and extended break touch nothing.
        deliverKey(8'h1C);
        checkOutput("repressCount", 32'(bus.key_count), 32'd2);
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        idleCycles(2);
        checkOutput("extCount", 32'(bus.key_count), 32'd2);
        checkOutput("extDown",  32'(bus.key_down),  32'd1);
        checkOutput("extHeld",  32'(bus.scan_out),  32'h1C);
        checkOutput("extValid", 32'(bus.key_valid), 32'd0);
        deliverKey(8'h1C);
        checkOutput("extThenRepeat", 32'(bus.key_count), 32'd2);

        // Back-pressure: the event stays put and the next byte waits.
        bus.key_ready = 1'b0;
        applyStimulus(8'h32);
        idleCycles(1);
        @(negedge clk);
        bus.code_valid = 1'b1;
        bus.code       = 8'h21;
        idleCycles(10);
        checkOutput("bpValid", 32'(bus.key_valid),  32'd1);
        checkOutput("bpAscii", 32'(bus.key_ascii),  32'h42);
        checkOutput("bpScan",  32'(bus.key_scan),   32'h32);
        checkOutput("bpReady", 32'(bus.code_ready), 32'd0);
        checkOutput("bpCount", 32'(bus.key_count),  32'd2);
        @(negedge clk);
        bus.key_ready = 1'b1;
        applyStimulus(8'h21);
        idleCycles(1);
        checkOutput("queuedAscii", 32'(bus.key_ascii), 32'h43);
        checkOutput("queuedScan",  32'(bus.key_scan),  32'h21);
        idleCycles(1);
        checkOutput("queuedCount", 32'(bus.key_count), 32'd4);

        // Unmapped key: held but no event.
        deliverKey(8'h0E);
        checkOutput("unmapValid", 32'(bus.key_valid), 32'd0);
        checkOutput("unmapCount", 32'(bus.key_count), 32'd4);
        checkOutput("unmapDown",  32'(bus.key_down),  32'd1);
        checkOutput("unmapHeld",  32'(bus.scan_out),  32'h0E);

        // Counter wrap: 251 more events reach 255, the next one wraps to 0.
        for (int i = 0; i < 251; i++) begin
            deliverKey(i[0] ? 8'h32 : 8'h1C);
        end
        checkOutput("count255", 32'(bus.key_count), 32'd255);
        deliverKey(8'h32);
        checkOutput("countWrap", 32'(bus.key_count), 32'd0);
        deliverKey(8'h1C);
        checkOutput("countAfterWrap", 32'(bus.key_count), 32'd1);

        // Reset while an event is pending in OUT abandons it immediately.
        bus.key_ready = 1'b0;
        applyStimulus(8'h32);
        idleCycles(1);
        checkOutput("pendValid", 32'(bus.key_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstValid", 32'(bus.key_valid), 32'd0);
        checkOutput("asyncRstCount", 32'(bus.key_count), 32'd0);
        checkOutput("asyncRstDown",  32'(bus.key_down),  32'd0);
        checkOutput("asyncRstScan",  32'(bus.scan_out),  32'h00);
        idleCycles(1);
        rst = 1'b0;
        idleCycles(1);
        checkOutput("rstReleaseReady", 32'(bus.code_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the keypress counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high (one clock; reset is asynchronous and active-high).
REQ-004 SHALL have port code_valid  input  1  raw scan byte available from PS/2 receiver FIFO.
REQ-005 SHALL have port code  input  8  raw scan byte (make, E0, F0).
REQ-006 SHALL have port code_ready  output  1  byte consumed when code_valid & code_ready at a clock edge.
REQ-007 SHALL have port scan_out  output  8  scan code driven to the combinational scan-to-ASCII lookup.
REQ-008 SHALL have port ascii_in  input  8  lookup result for scan_out; 0x00 = unmapped.
REQ-009 SHALL have port key_valid  output  1  key event valid.
REQ-010 SHALL have port key_ready  input  1  consumer accepts event when key_valid & key_ready.
REQ-011 SHALL have port key_ascii  output  8  ASCII of event.
REQ-012 SHALL have port key_scan  output  8  scan code of event.
REQ-013 SHALL have port key_down  output  1  a key is currently held.
REQ-014 SHALL have port key_count  output  CNT_W  number of events delivered.

Function
REQ-015 SHALL implement states IDLE, EXT, BREAK, LOOK, OUT.
REQ-016 SHALL drive code_ready=1 in IDLE, EXT, BREAK; 0 in LOOK, OUT.
REQ-017 IDLE, accepted 0xE0 -> EXT; 0xF0 -> BREAK.
REQ-018 IDLE, accepted other byte equal to held scan while key_down=1 (typematic repeat) -> discard, stay IDLE, no event.
REQ-019 IDLE, accepted other byte not a repeat -> latch into held scan register, key_down<=1, -> LOOK.
REQ-020 scan_out SHALL equal the held scan register at all times.
REQ-021 LOOK (one cycle): sample ascii_in; nonzero -> latch key_ascii, key_scan, -> OUT; zero -> IDLE, no event, key_down stays 1.
REQ-022 OUT: key_valid=1, key_ascii/key_scan stable until key_ready=1; on handshake key_count<=key_count+1, -> IDLE.
REQ-023 key_valid SHALL be 1 only in OUT; first assertion 2 cycles after the make byte acceptance edge.
REQ-024 BREAK, accepted byte equal to held scan -> key_down<=0; any byte -> IDLE; no event.
REQ-025 EXT, accepted 0xF0 -> BREAK with extended flag set; other byte -> IDLE, no event, held scan and key_down unchanged.
REQ-026 Extended break (flag set) SHALL consume next byte and not change key_down; flag cleared on exit to IDLE.
REQ-027 key_count SHALL wrap modulo 2^CNT_W (max -> 0).
REQ-028 Handshake on same edge as key_valid rises is impossible; key_ready while not OUT SHALL have no effect.
REQ-029 code_valid while code_ready=0 SHALL not be consumed; byte remains for later.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, key_valid=0, key_down=0, key_ascii=0, key_scan=0, held scan=0 (scan_out=0), key_count=0, extended flag=0.
REQ-031 rst asserted in any state including OUT SHALL abandon the pending event without incrementing key_count.
REQ-032 code_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-033 Push 0x1C, lookup returns 0x41, key_ready=1 -> key_valid 2 cycles after accept, key_ascii=0x41, key_scan=0x1C, key_count=1, key_down=1.
REQ-034 Push 0x1C,0x1C,0x1C -> exactly one event; then 0xF0,0x1C -> key_down=0, no event.
REQ-035 Push 0xE0,0x75 then 0xE0,0xF0,0x75 -> no events, key_down and key_count unchanged.
REQ-036 Push 0x32 with key_ready=0 for 10 cycles, 0x21 queued -> key_valid held, key_ascii=0x42 stable, code_ready=0; after key_ready=1, 0x21 yields 0x43.
REQ-037 Push 0x0E with ascii_in=0x00 -> no event, key_count unchanged, key_down=1.
REQ-038 Preload 255 events (CNT_W=8) then one more -> key_count 255 -> 0; assert rst during OUT -> key_valid=0, key_count=0 immediately.
